mlp_argmax: RTL and testbench

- Classification stage directly downstream of the output-layer neurons (10 neurons, 16-bit signed scores, no ReLU).
- Accepts one score per beat over a valid/ready stream, tracks the running maximum, and emits the winning digit index and its score once per frame.
- Stalls upstream while a result is waiting to be consumed.

---
 rtl/mlp_pkg.sv | 22 ++
 rtl/argmax_cmp.sv | 21 ++
 rtl/mlp_argmax.sv | 159 +++++++++++++++
 tb/tb_mlp_argmax.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
//==============================================================================
// Module : mlp_pkg
// Brief  : Shared types and constants for the MLP argmax classification stage.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package mlp_pkg;

    localparam int N_OUT = 10;
    localparam int IDX_W = 4;

    typedef logic signed [15:0] score_t;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/argmax_cmp.sv
//==============================================================================
// Module : argmax_cmp
// Brief  : Signed compare-select; flags a candidate strictly greater than best.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module argmax_cmp #(
    parameter int DATA_W = 16
) (
    input  logic signed [DATA_W-1:0] i_cand,
    input  logic signed [DATA_W-1:0] i_best,
    output logic                     o_take_new
);

    // Strictly greater keeps the earlier (lower) index on a tie.
    assign o_take_new = (i_cand > i_best);

endmodule

`default_nettype wire

// File: rtl/mlp_argmax.sv
//==============================================================================
// Module : mlp_argmax
// Brief  : Streaming argmax over output-layer scores; one result per frame.
//          Define ARGMAX_MARGIN_EN to add runner-up tracking and class_margin.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module mlp_argmax
    import mlp_pkg::*;
#(
    parameter int N_CLASSES = N_OUT,
    parameter int DATA_W    = 16,
    parameter int IDX_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              score_valid,
    output logic              score_ready,
    input  logic [DATA_W-1:0] score_data,
    input  logic              score_last,
    output logic              class_valid,
    input  logic              class_ready,
    output logic [IDX_W-1:0]  class_idx,
    output logic [DATA_W-1:0] class_score,
`ifdef ARGMAX_MARGIN_EN
    output logic [DATA_W-1:0] class_margin,
`endif
    output logic              frame_err
);

    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_CLASSES - 1);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [IDX_W-1:0]          r_count;
    logic signed [DATA_W-1:0]  r_best_score;
    logic [IDX_W-1:0]          r_best_idx;
    logic                      r_frame_err;

    logic signed [DATA_W-1:0]  w_score;
    logic                      w_beat;
    logic                      w_first;
    logic                      w_last_cnt;
    logic                      w_frame_end;
    logic                      w_take_best;

    assign w_score     = score_data;
    assign w_beat      = score_valid && score_ready;
    assign w_first     = (r_count == '0);
    assign w_last_cnt  = (r_count == c_LAST_IDX);
    assign w_frame_end = score_last || w_last_cnt;

    argmax_cmp #(
        .DATA_W     (DATA_W)
    ) u_cmp_best (
        .i_cand     (w_score),
        .i_best     (r_best_score),
        .o_take_new (w_take_best)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACCUM:   if (w_beat && w_frame_end) w_state_next = HOLD;
            HOLD:    if (class_ready)           w_state_next = ACCUM;
            default: w_state_next = ACCUM;
        endcase
    end

    always_comb begin
        score_ready = 1'b0;
        class_valid = 1'b0;
        case (r_state)
            ACCUM:   score_ready = 1'b1;
            HOLD:    class_valid = 1'b1;
            default: score_ready = 1'b1;
        endcase
    end

    // Best registers drive the outputs directly; they only move in ACCUM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count      <= '0;
            r_best_score <= '0;
            r_best_idx   <= '0;
            r_frame_err  <= 1'b0;
        end else if (w_beat) begin
            if (w_frame_end) begin
                r_count     <= '0;
                r_frame_err <= (score_last != w_last_cnt);
            end else begin
                r_count     <= r_count + 1'b1;
            end
            if (w_first || w_take_best) begin
                r_best_score <= w_score;
                r_best_idx   <= r_count;
            end
        end
    end

    assign class_idx   = r_best_idx;
    assign class_score = r_best_score;
    assign frame_err   = r_frame_err;

`ifdef ARGMAX_MARGIN_EN
    logic signed [DATA_W-1:0]  r_second;
    logic                      r_second_valid;
    logic                      w_take_second;
    logic [DATA_W:0]           w_diff;

    argmax_cmp #(
        .DATA_W     (DATA_W)
    ) u_cmp_second (
        .i_cand     (w_score),
        .i_best     (r_second),
        .o_take_new (w_take_second)
    );

    // A displaced best becomes the runner-up; otherwise the beat may replace it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_second       <= '0;
            r_second_valid <= 1'b0;
        end else if (w_beat) begin
            if (w_first) begin
                r_second_valid <= 1'b0;
            end else if (w_take_best) begin
                r_second       <= r_best_score;
                r_second_valid <= 1'b1;
            end else if (!r_second_valid || w_take_second) begin
                r_second       <= w_score;
                r_second_valid <= 1'b1;
            end
        end
    end

    assign w_diff = {r_best_score[DATA_W-1], r_best_score}
                  - {r_second[DATA_W-1], r_second};

    always_comb begin
        class_margin = '1;
        if (r_second_valid && !w_diff[DATA_W]) begin
            class_margin = w_diff[DATA_W-1:0];
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mlp_argmax.sv
//==============================================================================
// Module : tb_mlp_argmax
// Brief  : Directed scoreboard bench for mlp_argmax (ARGMAX_MARGIN_EN aware).
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_mlp_argmax;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        score_valid;
    logic        score_ready;
    logic [15:0] score_data;
    logic        score_last;
    logic        class_valid;
    logic        class_ready;
    logic [3:0]  class_idx;
    logic [15:0] class_score;
    logic        frame_err;
`ifdef ARGMAX_MARGIN_EN
    logic [15:0] class_margin;
`endif

    mlp_argmax #(
        .N_CLASSES   (10),
        .DATA_W      (16),
        .IDX_W       (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .score_valid (score_valid),
        .score_ready (score_ready),
        .score_data  (score_data),
        .score_last  (score_last),
        .class_valid (class_valid),
        .class_ready (class_ready),
        .class_idx   (class_idx),
        .class_score (class_score),
`ifdef ARGMAX_MARGIN_EN
        .class_margin(class_margin),
`endif
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  idx;
        logic [15:0] score;
        logic        err;
        logic [15:0] margin;
    } exp_t;

    exp_t        sb[$];
    int          vectors    = 0;
    int          miscompares = 0;
    logic [15:0] fv [0:9];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [15:0] d, input logic last);
        int t;
        @(negedge clk);
        score_valid = 1'b1;
        score_data  = d;
        score_last  = last;
        t = 0;
        while (!score_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!score_ready) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    task automatic send_frame(input int n, input logic use_last, input logic [3:0] eidx,
                              input logic [15:0] escore, input logic eerr,
                              input logic [15:0] emargin);
        exp_t e;
        e.idx = eidx; e.score = escore; e.err = eerr; e.margin = emargin;
        sb.push_back(e);
        for (int i = 0; i < n; i++) send_beat(fv[i], use_last && (i == n - 1));
        @(negedge clk);
        score_valid = 1'b0;
        score_last  = 1'b0;
        chk("latency_valid", {31'd0, class_valid}, 32'd1);
    endtask

    task automatic take_result(input int hold_cycles);
        exp_t e;
        int   t;
        t = 0;
        while (!class_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!class_valid) begin
            chk("valid_timeout", 32'd0, 32'd1);
        end else if (sb.size() == 0) begin
            chk("sb_underflow", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("class_idx", {28'd0, class_idx}, {28'd0, e.idx});
            chk("class_score", {16'd0, class_score}, {16'd0, e.score});
            chk("frame_err", {31'd0, frame_err}, {31'd0, e.err});
`ifdef ARGMAX_MARGIN_EN
            chk("class_margin", {16'd0, class_margin}, {16'd0, e.margin});
`endif
            // Offer a decoy beat while the result is held; it must not be taken.
            for (int h = 0; h < hold_cycles; h++) begin
                score_valid = 1'b1;
                score_data  = 16'h7FFF;
                score_last  = 1'b1;
                @(negedge clk);
                chk("hold_idx", {28'd0, class_idx}, {28'd0, e.idx});
                chk("hold_score", {16'd0, class_score}, {16'd0, e.score});
                chk("hold_err", {31'd0, frame_err}, {31'd0, e.err});
                chk("hold_ready", {31'd0, score_ready}, 32'd0);
                chk("hold_valid", {31'd0, class_valid}, 32'd1);
            end
            score_valid = 1'b0;
            score_last  = 1'b0;
            class_ready = 1'b1;
            @(negedge clk);
            class_ready = 1'b0;
            chk("accum_ready", {31'd0, score_ready}, 32'd1);
            chk("accum_valid", {31'd0, class_valid}, 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        score_valid = 1'b0;
        score_data  = 16'd0;
        score_last  = 1'b0;
        class_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, score_ready}, 32'd1);
        chk("rst_valid", {31'd0, class_valid}, 32'd0);
        chk("rst_idx", {28'd0, class_idx}, 32'd0);
        chk("rst_score", {16'd0, class_score}, 32'd0);
        chk("rst_err", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;

        // Mixed scores with a tie at 20: lowest index (2) wins; held 5 cycles.
        fv = '{16'd5, 16'hFFFD, 16'd20, 16'd7, 16'd20, 16'd1, 16'd0, 16'hFFFF, 16'd2, 16'd19};
        send_frame(10, 1'b1, 4'd2, 16'd20, 1'b0, 16'd0);
        take_result(5);

        // All most-negative scores.
        for (int i = 0; i < 10; i++) fv[i] = 16'h8000;
        send_frame(10, 1'b1, 4'd0, 16'h8000, 1'b0, 16'd0);
        take_result(0);

        // Short frame: last on beat 4.
        fv = '{16'd1, 16'd2, 16'd9, 16'd3, 16'd4, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        send_frame(5, 1'b1, 4'd2, 16'd9, 1'b1, 16'd5);
        take_result(0);

        // Ascending -5..4 proves the count restarted at 0.
        for (int i = 0; i < 10; i++) fv[i] = 16'(i - 5);
        send_frame(10, 1'b1, 4'd9, 16'd4, 1'b0, 16'd1);
        take_result(0);

        // Reset after beat 6 discards the partial frame.
        for (int i = 0; i < 7; i++) send_beat(16'd100, 1'b0);
        @(negedge clk);
        score_valid = 1'b0;
        rst_n       = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_valid", {31'd0, class_valid}, 32'd0);
        chk("midrst_ready", {31'd0, score_ready}, 32'd1);
        chk("midrst_score", {16'd0, class_score}, 32'd0);
        fv = '{16'd3, 16'd8, 16'hFFFE, 16'd8, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1};
        send_frame(10, 1'b1, 4'd1, 16'd8, 1'b0, 16'd0);
        take_result(0);

        // Ten beats without last: count terminates the frame, flagged as error.
        for (int i = 0; i < 9; i++) fv[i] = 16'd0;
        fv[9] = 16'd50;
        send_frame(10, 1'b0, 4'd9, 16'd50, 1'b1, 16'd50);
        take_result(0);

        // Single-beat frame.
        fv[0] = 16'h1234;
        send_frame(1, 1'b1, 4'd0, 16'h1234, 1'b1, 16'hFFFF);
        take_result(0);

        // Extreme spread: best 0x7FFF, runner-up 0x8000.
        fv[0] = 16'h8000;
        fv[1] = 16'h7FFF;
        send_frame(2, 1'b1, 4'd1, 16'h7FFF, 1'b1, 16'hFFFF);
        take_result(0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
